// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing block.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int RGB_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525

  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;          // 656
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;    // 752
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;          // 490
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;    // 492

  // Control bits that travel alongside the pixel through the source latency.
  // hs/vs here are "sync asserted" flags, independent of pin polarity.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } raster_ctl_t;

  // True when cnt lies in [lo, lo+len).
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to match control bits to the pixel
// source latency. DEPTH=0 collapses to a plain wire.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = vga_clk ^ RST;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift din through DEPTH stages; reset flushes every stage to RST_VAL.
      always_ff @(posedge vga_clk or negedge RST) begin
        if (!RST) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster master: free-running h/v counters issue pixel requests, control
// bits are delayed by the source latency, and a final register drives the
// DAC pins so sync, blank and colour for one pixel leave on the same edge.
//
// Source contract: the pixel source sees xPos/yPos and must present the
// matching colour on iRed/iGreen/iBlue exactly PIX_LAT clocks later. There
// is no valid/ready; colour inputs are ignored whenever the delayed active
// flag is low, so the source may drive anything during blanking.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIX_LAT  = 1
) (
  input  logic             vga_clk,
  input  logic             RST,
  output logic [CNT_W-1:0] xPos,
  output logic [CNT_W-1:0] yPos,
  input  logic [RGB_W-1:0] iRed,
  input  logic [RGB_W-1:0] iGreen,
  input  logic [RGB_W-1:0] iBlue,
  output logic [RGB_W-1:0] oVGA_R,
  output logic [RGB_W-1:0] oVGA_G,
  output logic [RGB_W-1:0] oVGA_B,
  output logic             oVGA_HS,
  output logic             oVGA_VS,
  output logic             oVGA_BLANK_N,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START   = H_ACTIVE + H_FP;
  localparam int VS_START   = V_ACTIVE + V_FP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  raster_ctl_t      req_ctl;
  raster_ctl_t      dly_ctl;
  logic             h_vis;
  logic             v_vis;

  // Raster counters: h runs over the whole line, v advances when h wraps.
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
    end else begin
      h_cnt <= h_cnt + CNT_ONE;
    end
  end

  // Request-side decode straight from the counters.
  always_comb begin
    h_vis          = (int'(h_cnt) < H_ACTIVE);
    v_vis          = (int'(v_cnt) < V_ACTIVE);
    req_ctl        = '0;
    req_ctl.active = h_vis && v_vis;
    req_ctl.hs     = in_window(h_cnt, HS_START, H_SYNC);
    req_ctl.vs     = in_window(v_cnt, VS_START, V_SYNC);
    xPos           = h_vis ? h_cnt : '0;
    yPos           = v_vis ? v_cnt : '0;
    frame_start    = (h_cnt == '0) && (v_cnt == '0);
    line_start     = (h_cnt == '0);
  end

  // Control bits wait PIX_LAT clocks so they meet the source's colour.
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIX_LAT),
    .RST_VAL (3'b000)
  ) u_ctl_dly (
    .vga_clk (vga_clk),
    .RST     (RST),
    .din     (req_ctl),
    .dout    (dly_ctl)
  );

  // Output register: all pin signals for one pixel update together.
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_BLANK_N <= 1'b0;
      oVGA_HS      <= ~SYNC_POL;
      oVGA_VS      <= ~SYNC_POL;
    end else begin
      oVGA_BLANK_N <= dly_ctl.active;
      oVGA_HS      <= dly_ctl.hs ? SYNC_POL : ~SYNC_POL;
      oVGA_VS      <= dly_ctl.vs ? SYNC_POL : ~SYNC_POL;
      if (dly_ctl.active) begin
        oVGA_R <= iRed;
        oVGA_G <= iGreen;
        oVGA_B <= iBlue;
      end else begin
        oVGA_R <= '0;
        oVGA_G <= '0;
        oVGA_B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: one full-size instance with a registered
// pattern source, plus two reduced-geometry instances (latency 0 and 3)
// whose source echoes xPos on red, so whole frames fit in a short run.
module tb_vga_timing_ctrl;

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic RST     = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // edges since the last reset release; request index after edge n is n
  int edge_n = 0;
  always @(posedge vga_clk) begin
    if (!RST) edge_n <= 0;
    else      edge_n <= edge_n + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- full-size instance, PIX_LAT=1 ----------------
  logic [9:0] f_x, f_y, f_ir, f_ig, f_ib, f_r, f_g, f_b;
  logic       f_hs, f_vs, f_blank, f_fs, f_ls;

  // registered pattern: 8 colour bars in x, red also ramps in y
  always @(posedge vga_clk) begin
    f_ir <= 10'(3 + int'(f_x) / 80 + int'(f_y) / 80);
    f_ig <= 10'(1 + 2 * (int'(f_x) / 80));
    f_ib <= 10'(15 - 2 * (int'(f_x) / 80));
  end

  vga_timing_ctrl #(.PIX_LAT(1)) dut_f (
    .vga_clk(vga_clk), .RST(RST), .xPos(f_x), .yPos(f_y),
    .iRed(f_ir), .iGreen(f_ig), .iBlue(f_ib),
    .oVGA_R(f_r), .oVGA_G(f_g), .oVGA_B(f_b),
    .oVGA_HS(f_hs), .oVGA_VS(f_vs), .oVGA_BLANK_N(f_blank),
    .frame_start(f_fs), .line_start(f_ls)
  );

  // ---------------- reduced geometry: 24 x 19, 16 x 12 visible ----------------
  localparam int S_HT = 24, S_VT = 19, S_HA = 16, S_VA = 12;
  localparam int S_HS0 = 18, S_HS1 = 21, S_VS0 = 14, S_VS1 = 16;

  logic [9:0] z_x, z_y, z_r, z_g, z_b;
  logic       z_hs, z_vs, z_blank, z_fs, z_ls;
  logic [9:0] t_x, t_y, t_r, t_g, t_b, t_d1, t_d2, t_d3;
  logic       t_hs, t_vs, t_blank, t_fs, t_ls;

  // three-register echo source for the latency-3 instance
  always @(posedge vga_clk) begin
    t_d1 <= t_x;
    t_d2 <= t_d1;
    t_d3 <= t_d2;
  end

  vga_timing_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LAT(0)) dut_z (
    .vga_clk(vga_clk), .RST(RST), .xPos(z_x), .yPos(z_y),
    .iRed(z_x), .iGreen(10'd0), .iBlue(10'd0),
    .oVGA_R(z_r), .oVGA_G(z_g), .oVGA_B(z_b),
    .oVGA_HS(z_hs), .oVGA_VS(z_vs), .oVGA_BLANK_N(z_blank),
    .frame_start(z_fs), .line_start(z_ls)
  );

  vga_timing_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LAT(3)) dut_t (
    .vga_clk(vga_clk), .RST(RST), .xPos(t_x), .yPos(t_y),
    .iRed(t_d3), .iGreen(10'd0), .iBlue(10'd0),
    .oVGA_R(t_r), .oVGA_G(t_g), .oVGA_B(t_b),
    .oVGA_HS(t_hs), .oVGA_VS(t_vs), .oVGA_BLANK_N(t_blank),
    .frame_start(t_fs), .line_start(t_ls)
  );

  // expected {blank_n, hs, vs, red} on the pins after edge n, closed form
  function automatic logic [12:0] small_exp(input int lat, input int n);
    int m, h, v;
    logic act;
    m = n - 1 - lat;
    if (m < 0) return {1'b0, 1'b1, 1'b1, 10'd0};
    m   = m % (S_HT * S_VT);
    h   = m % S_HT;
    v   = m / S_HT;
    act = (h < S_HA) && (v < S_VA);
    return {act, !(h >= S_HS0 && h < S_HS1), !(v >= S_VS0 && v < S_VS1),
            act ? 10'(h) : 10'd0};
  endfunction

  // per-clock raster conformance of the reduced instances (incl. gated G/B)
  int z_err = 0, t_err = 0;
  always @(negedge vga_clk) begin
    if (RST && edge_n >= 1) begin
      if ({z_blank, z_hs, z_vs, z_r} !== small_exp(0, edge_n) || (z_g | z_b) !== 10'd0)
        z_err <= z_err + 1;
      if ({t_blank, t_hs, t_vs, t_r} !== small_exp(3, edge_n) || (t_g | t_b) !== 10'd0)
        t_err <= t_err + 1;
    end
  end

  // full-size line measurements over the first two output lines (n 2..1601)
  int hs_low_cnt = 0, blank_hi_cnt = 0, blank_fall_n = -1, hs_fall_n = -1;
  logic f_prev_blank = 1'b0, f_prev_hs = 1'b1;
  always @(negedge vga_clk) begin
    if (RST) begin
      f_prev_blank <= f_blank;
      f_prev_hs    <= f_hs;
      if (edge_n >= 2 && edge_n <= 1601) begin
        if (!f_hs)   hs_low_cnt   <= hs_low_cnt + 1;
        if (f_blank) blank_hi_cnt <= blank_hi_cnt + 1;
        if (f_prev_blank && !f_blank && blank_fall_n < 0) blank_fall_n <= edge_n;
        if (f_prev_hs && !f_hs && hs_fall_n < 0) hs_fall_n <= edge_n;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input integer act, input integer exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_n(input int target);
    int budget;
    budget = 0;
    while (edge_n < target && budget < 20000) begin
      @(negedge vga_clk);
      budget++;
    end
    if (edge_n < target) chk("wait_budget", edge_n, target);
  endtask

  // ---------------- vector table for the full-size instance ----------------
  typedef struct {
    int n, blank, hs, vs, r, g, b, x, y, fs, ls;
  } vec_t;
  vec_t vecs[11];

  int t_rise, z_rise, t_vs_low, t_vs_fall, budget;
  logic prev_t_vs;

  initial begin
    //           n     bl hs vs  r  g  b    x  y  fs ls
    vecs[0]  = '{1,    0, 1, 1,  0, 0, 0,   1, 0, 0, 0};
    vecs[1]  = '{2,    1, 1, 1,  3, 1, 15,  2, 0, 0, 0};
    vecs[2]  = '{82,   1, 1, 1,  4, 3, 13, 82, 0, 0, 0};
    vecs[3]  = '{641,  1, 1, 1, 10, 15, 1,  0, 0, 0, 0};
    vecs[4]  = '{642,  0, 1, 1,  0, 0, 0,   0, 0, 0, 0};
    vecs[5]  = '{658,  0, 0, 1,  0, 0, 0,   0, 0, 0, 0};
    vecs[6]  = '{753,  0, 0, 1,  0, 0, 0,   0, 0, 0, 0};
    vecs[7]  = '{754,  0, 1, 1,  0, 0, 0,   0, 0, 0, 0};
    vecs[8]  = '{800,  0, 1, 1,  0, 0, 0,   0, 1, 0, 1};
    vecs[9]  = '{802,  1, 1, 1,  3, 1, 15,  2, 1, 0, 0};
    vecs[10] = '{1000, 1, 1, 1,  5, 5, 11, 200, 1, 0, 0};

    // reset held for 10 clocks
    RST = 1'b0;
    repeat (10) @(posedge vga_clk);
    @(negedge vga_clk);
    #1;
    chk("rst_R", f_r, 0);
    chk("rst_G", f_g, 0);
    chk("rst_B", f_b, 0);
    chk("rst_blank_n", f_blank, 0);
    chk("rst_hs", f_hs, 1);
    chk("rst_vs", f_vs, 1);
    chk("rst_xpos", f_x, 0);
    chk("rst_ypos", f_y, 0);
    chk("rst_t_hs", t_hs, 1);
    chk("rst_t_blank_n", t_blank, 0);

    // release between edges; the first edge must see frame_start/line_start
    #1 RST = 1'b1;
    #1;
    chk("frame_start_at_first_edge", f_fs, 1);
    chk("line_start_at_first_edge", f_ls, 1);

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      wait_n(vecs[i].n);
      chk($sformatf("v%0d_n%0d_blank_n", i, vecs[i].n), f_blank, vecs[i].blank);
      chk($sformatf("v%0d_n%0d_hs", i, vecs[i].n), f_hs, vecs[i].hs);
      chk($sformatf("v%0d_n%0d_vs", i, vecs[i].n), f_vs, vecs[i].vs);
      chk($sformatf("v%0d_n%0d_R", i, vecs[i].n), f_r, vecs[i].r);
      chk($sformatf("v%0d_n%0d_G", i, vecs[i].n), f_g, vecs[i].g);
      chk($sformatf("v%0d_n%0d_B", i, vecs[i].n), f_b, vecs[i].b);
      chk($sformatf("v%0d_n%0d_xpos", i, vecs[i].n), f_x, vecs[i].x);
      chk($sformatf("v%0d_n%0d_ypos", i, vecs[i].n), f_y, vecs[i].y);
      chk($sformatf("v%0d_n%0d_frame_start", i, vecs[i].n), f_fs, vecs[i].fs);
      chk($sformatf("v%0d_n%0d_line_start", i, vecs[i].n), f_ls, vecs[i].ls);
    end

    // line timing over two full output lines
    wait_n(1602);
    chk("hs_low_clks_2lines", hs_low_cnt, 192);
    chk("blank_hi_clks_2lines", blank_hi_cnt, 1280);
    chk("blank_fall_edge", blank_fall_n, 642);
    chk("hs_fall_after_blank_fall", hs_fall_n - blank_fall_n, 16);

    // frame_start on the reduced raster at a frame boundary (456 clocks/frame)
    wait_n(1823);
    chk("small_frame_start_before", z_fs, 0);
    wait_n(1824);
    chk("small_frame_start_z", z_fs, 1);
    chk("small_frame_start_t", t_fs, 1);

    // mid-frame reset with the reduced raster at (h=10, v=5)
    wait_n(1954);
    chk("pre_rst_t_xpos", t_x, 10);
    chk("pre_rst_t_ypos", t_y, 5);
    chk("pre_rst_t_blank_n", t_blank, 1);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_t_blank_n", t_blank, 0);
    chk("mid_rst_t_R", t_r, 0);
    chk("mid_rst_t_hs", t_hs, 1);
    chk("mid_rst_t_vs", t_vs, 1);
    chk("mid_rst_t_xpos", t_x, 0);
    chk("mid_rst_t_ypos", t_y, 0);
    chk("mid_rst_f_blank_n", f_blank, 0);
    chk("mid_rst_f_R", f_r, 0);
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    #2 RST = 1'b1;
    #1;
    chk("restart_t_xpos", t_x, 0);
    chk("restart_t_ypos", t_y, 0);
    chk("restart_t_frame_start", t_fs, 1);

    // first frame after the restart
    t_rise = -1; z_rise = -1; t_vs_low = 0; t_vs_fall = -1;
    prev_t_vs = 1'b1; budget = 0;
    while (edge_n < 460 && budget < 2000) begin
      @(negedge vga_clk);
      budget++;
      if (edge_n == 1) chk("restart_t_xpos_edge1", t_x, 1);
      if (t_blank && t_rise < 0) t_rise = edge_n;
      if (z_blank && z_rise < 0) z_rise = edge_n;
      if (edge_n >= 4 && edge_n <= 459 && !t_vs) t_vs_low++;
      if (prev_t_vs && !t_vs && t_vs_fall < 0) t_vs_fall = edge_n;
      prev_t_vs = t_vs;
    end
    chk("restart_wait_budget", edge_n, 460);
    chk("restart_first_blank_rise_lat3", t_rise, 4);
    chk("restart_first_blank_rise_lat0", z_rise, 1);
    chk("restart_vs_low_clks_frame", t_vs_low, 48);
    chk("restart_vs_fall_edge", t_vs_fall, 340);

    // whole-run raster conformance of the reduced instances
    chk("raster_err_count_lat0", z_err, 0);
    chk("raster_err_count_lat3", t_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
